sdram_arbiter: RTL and testbench
================================

# sdram_arbiter

Sequences and shares the single SDRAM command port between the CPU memory slot (read, write, refresh strobed by the machine's memory clock enable) and a byte-wide loader port that streams ROM images into SDRAM. Sits between `main`'s mem* signals plus the boot/flash loader and the `sdram` controller. Drives the controller's active-low rfsh/rd/wr strobes and returns CPU read data. The CPU always has priority; the loader fills the idle gaps.

## Interface
- TCMD, 8: clocks from one command strobe to the earliest next strobe (controller occupancy); 2..15.
- TRD, 6: clocks from a read strobe to valid `sdrQ`; must satisfy 1 ≤ TRD ≤ TCMD-1.
- LAW, 24: loader address width.

- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ready  in  1  SDRAM controller initialised; no command issues while low
- cpuCe  in  1  one-clock slot strobe; cpuRf/Rd/Wr/A/D sampled only here
- cpuRf  in  1  refresh request (active high)
- cpuRd  in  1  read request (active high)
- cpuWr  in  1  write request (active high)
- cpuA  in  19  CPU byte address
- cpuD  in  8  CPU write data
- cpuQ  out  8  CPU read data, held until next CPU read completes
- cpuQv  out  1  one-clock pulse when cpuQ updates
- ldReq  in  1  loader write request, level, held until ldAck
- ldA  in  LAW  loader address
- ldD  in  8  loader data
- ldAck  out  1  one-clock pulse: loader write issued, ldA/ldD may change next clock
- busy  out  1  high in CMD or WAIT
- ovr  out  1  sticky: CPU request arrived while a CPU request was still pending
- sdrRf, sdrRd, sdrWr  out  1 each  active-low strobes to controller
- sdrA  out  24  controller address
- sdrD  out  16  controller write data
- sdrQ  in  16  controller read data

## Operation
- Pending register (valid, kind, addr, data). On cpuCe with any request: load it; kind priority Wr > Rd > Rf, one command only. cpuCe with no request bit: no change. If valid already set and not being consumed this clock: overwrite, set ovr.
- States IDLE, CMD, WAIT.
- IDLE, ready=1: if pending valid (or cpuCe with request this clock, bypassing the register) → CMD with CPU command; else if ldReq → CMD with loader write; else stay. ready=0: stay, requests keep pending.
- CMD (exactly one clock): assert selected strobe low; sdrA = {5'd0,cpuA} (CPU) or ldA zero-extended to 24 (loader); sdrD = {2{data}}; clear pending valid if CPU; ldAck=1 if loader; load counter with TCMD-2 → WAIT (TCMD=2: WAIT lasts 0 clocks, go IDLE).
- WAIT: strobes high, sdrA/sdrD held; decrement; at 0 → IDLE.
- CPU read: TRD clocks after the CMD clock, cpuQ <= sdrQ[7:0], cpuQv=1 for that clock. Refresh and writes produce no cpuQv.
- Loader never preempts: a CPU request pending at IDLE always wins; loader waits indefinitely while CPU keeps the port busy.

## Timing
- All outputs registered. Reset values: sdrRf=sdrRd=sdrWr=1, sdrA=0, sdrD=0, cpuQ=8'hFF, cpuQv=0, ldAck=0, busy=0, ovr=0; state IDLE, pending cleared, counter 0.
- cpuCe at clock n, arbiter IDLE: strobe low at n+1, busy high n+1..n+TCMD-1, IDLE at n+TCMD.
- Back-to-back strobes exactly TCMD clocks apart minimum.
- cpuCe during CMD/WAIT: issued at first IDLE clock + 1; worst-case CPU latency = TCMD clocks (one loader op in flight).
- cpuCe and ldReq same clock in IDLE: CPU issued, loader next free slot.
- ldReq dropped before ack: no command issued, no ack.
- ready falling during WAIT: current op completes its count; no new command until ready=1.
- reset mid-operation: strobes return high asynchronously; pending read data never delivered; ovr cleared.

## Test plan
- Reset: assert reset mid-WAIT → all strobes 1, sdrA=0, cpuQ=FF, busy=0 same clock; release → IDLE, no strobe.
- CPU read: cpuCe with cpuRd, cpuA=19'h2ABCD, sdrQ=16'h005A at strobe+6 → sdrRd low one clock at n+1, sdrA=24'h02ABCD, cpuQ=5A with cpuQv pulse at n+7.
- Priority: cpuCe with cpuWr=cpuRd=cpuRf=1, cpuD=C3 → only sdrWr strobes, sdrD=C3C3; simultaneous ldReq → ldAck exactly TCMD clocks later, sdrWr again, sdrA=ldA.
- Loader stream: ldReq held with 4 sequential addresses, no CPU → 4 ldAck pulses 8 clocks apart, sdrD={2{ldD}} each.
- Contention/overrun: loader op in flight, cpuCe rfsh at strobe+2 → sdrRf strobe at strobe+8; two cpuCe during one WAIT → ovr=1, only second request issued.
- ready=0 with pending cpuRd and ldReq → no strobes; ready rises → CPU read first, loader TCMD later.

Source files
------------

// File: rtl/sdram_arbiter.sv
// Shares the SDRAM controller command port between the CPU memory slot and a
// byte-wide ROM loader. The CPU always wins at an idle slot; the loader fills gaps.
module sdram_arbiter #(
    parameter int TCMD = 8,
    parameter int TRD  = 6,
    parameter int LAW  = 24
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           ready,
    input  logic           cpuCe,
    input  logic           cpuRf,
    input  logic           cpuRd,
    input  logic           cpuWr,
    input  logic [18:0]    cpuA,
    input  logic [7:0]     cpuD,
    output logic [7:0]     cpuQ,
    output logic           cpuQv,
    input  logic           ldReq,
    input  logic [LAW-1:0] ldA,
    input  logic [7:0]     ldD,
    output logic           ldAck,
    output logic           busy,
    output logic           ovr,
    output logic           sdrRf,
    output logic           sdrRd,
    output logic           sdrWr,
    output logic [23:0]    sdrA,
    output logic [15:0]    sdrD,
    input  logic [15:0]    sdrQ
);

    typedef enum logic [1:0] {IDLE, CMD, WAIT} state_t;
    typedef enum logic [1:0] {K_RF, K_RD, K_WR} kind_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  rd_cnt_q, rd_cnt_d;
    logic        pend_v_q, pend_v_d;
    kind_t       pend_kind_q, pend_kind_d;
    logic [18:0] pend_a_q, pend_a_d;
    logic [7:0]  pend_d_q, pend_d_d;
    logic        ovr_q, ovr_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        rdata_v_q, rdata_v_d;
    logic        ld_ack_q, ld_ack_d;
    logic        busy_q, busy_d;
    logic        sdr_rf_q, sdr_rf_d;
    logic        sdr_rd_q, sdr_rd_d;
    logic        sdr_wr_q, sdr_wr_d;
    logic [23:0] sdr_a_q, sdr_a_d;
    logic [15:0] sdr_d_q, sdr_d_d;

    logic        cpu_req, can_issue, issue_pend, issue_byp, issue_ld;
    kind_t       new_kind, cmd_kind;
    logic [18:0] cmd_a;
    logic [7:0]  cmd_dat;

    // Only the low byte of the controller read word is returned to the CPU.
    logic unused_sdrq_hi;
    assign unused_sdrq_hi = ^sdrQ[15:8];

    // NOTE: every variable gets its hold/idle value first, so no path through
    // the branches below can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_cnt_d    = rd_cnt_q;
        pend_v_d    = pend_v_q;
        pend_kind_d = pend_kind_q;
        pend_a_d    = pend_a_q;
        pend_d_d    = pend_d_q;
        ovr_d       = ovr_q;
        rdata_d     = rdata_q;
        rdata_v_d   = 1'b0;
        ld_ack_d    = 1'b0;
        sdr_rf_d    = 1'b1;
        sdr_rd_d    = 1'b1;
        sdr_wr_d    = 1'b1;
        sdr_a_d     = sdr_a_q;
        sdr_d_d     = sdr_d_q;

        cpu_req = cpuCe & (cpuRf | cpuRd | cpuWr);
        if (cpuWr)      new_kind = K_WR;
        else if (cpuRd) new_kind = K_RD;
        else            new_kind = K_RF;

        can_issue  = (state_q == IDLE) && ready;
        issue_pend = can_issue && pend_v_q;
        issue_byp  = can_issue && !pend_v_q && cpu_req;
        issue_ld   = can_issue && !pend_v_q && !cpu_req && ldReq;

        if (issue_pend) begin
            cmd_kind = pend_kind_q;
            cmd_a    = pend_a_q;
            cmd_dat  = pend_d_q;
            pend_v_d = 1'b0;
        end else begin
            cmd_kind = new_kind;
            cmd_a    = cpuA;
            cmd_dat  = cpuD;
        end

        // A fresh request lands in the pending slot unless it goes out directly.
        if (cpu_req) begin
            if (pend_v_q && !issue_pend) ovr_d = 1'b1;
            if (!issue_byp) begin
                pend_v_d    = 1'b1;
                pend_kind_d = new_kind;
                pend_a_d    = cpuA;
                pend_d_d    = cpuD;
            end
        end

        if (rd_cnt_q != 4'd0) begin
            rd_cnt_d = rd_cnt_q - 4'd1;
            if (rd_cnt_q == 4'd1) begin
                rdata_d   = sdrQ[7:0];
                rdata_v_d = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (issue_pend || issue_byp) begin
                    state_d = CMD;
                    sdr_a_d = {5'd0, cmd_a};
                    sdr_d_d = {2{cmd_dat}};
                    unique case (cmd_kind)
                        K_WR: sdr_wr_d = 1'b0;
                        K_RD: begin
                            sdr_rd_d = 1'b0;
                            rd_cnt_d = 4'(TRD);
                        end
                        default: sdr_rf_d = 1'b0;
                    endcase
                end else if (issue_ld) begin
                    state_d  = CMD;
                    sdr_a_d  = 24'(ldA);
                    sdr_d_d  = {2{ldD}};
                    sdr_wr_d = 1'b0;
                    ld_ack_d = 1'b1;
                end
            end
            CMD: begin
                if (TCMD == 2) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                    cnt_d   = 4'(TCMD - 2);
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before this edge, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            rd_cnt_q    <= 4'd0;
            pend_v_q    <= 1'b0;
            pend_kind_q <= K_RF;
            pend_a_q    <= '0;
            pend_d_q    <= '0;
            ovr_q       <= 1'b0;
            rdata_q     <= 8'hFF;
            rdata_v_q   <= 1'b0;
            ld_ack_q    <= 1'b0;
            busy_q      <= 1'b0;
            sdr_rf_q    <= 1'b1;
            sdr_rd_q    <= 1'b1;
            sdr_wr_q    <= 1'b1;
            sdr_a_q     <= '0;
            sdr_d_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            pend_v_q    <= pend_v_d;
            pend_kind_q <= pend_kind_d;
            pend_a_q    <= pend_a_d;
            pend_d_q    <= pend_d_d;
            ovr_q       <= ovr_d;
            rdata_q     <= rdata_d;
            rdata_v_q   <= rdata_v_d;
            ld_ack_q    <= ld_ack_d;
            busy_q      <= busy_d;
            sdr_rf_q    <= sdr_rf_d;
            sdr_rd_q    <= sdr_rd_d;
            sdr_wr_q    <= sdr_wr_d;
            sdr_a_q     <= sdr_a_d;
            sdr_d_q     <= sdr_d_d;
        end
    end

    assign cpuQ  = rdata_q;
    assign cpuQv = rdata_v_q;
    assign ldAck = ld_ack_q;
    assign busy  = busy_q;
    assign ovr   = ovr_q;
    assign sdrRf = sdr_rf_q;
    assign sdrRd = sdr_rd_q;
    assign sdrWr = sdr_wr_q;
    assign sdrA  = sdr_a_q;
    assign sdrD  = sdr_d_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed vectors and sequences plus random traffic,
// all checked every cycle against a slot-timing reference model.
module tb_sdram_arbiter;

    localparam int TCMD = 8;
    localparam int TRD  = 6;
    localparam int LAW  = 24;

    logic           clock = 1'b0;
    logic           reset, ready, cpuCe, cpuRf, cpuRd, cpuWr;
    logic [18:0]    cpuA;
    logic [7:0]     cpuD, cpuQ;
    logic           cpuQv, ldReq, ldAck, busy, ovr, sdrRf, sdrRd, sdrWr;
    logic [LAW-1:0] ldA;
    logic [7:0]     ldD;
    logic [23:0]    sdrA;
    logic [15:0]    sdrD, sdrQ;

    always #5 clock = ~clock;

    sdram_arbiter #(.TCMD(TCMD), .TRD(TRD), .LAW(LAW)) dut (
        .clock(clock), .reset(reset), .ready(ready),
        .cpuCe(cpuCe), .cpuRf(cpuRf), .cpuRd(cpuRd), .cpuWr(cpuWr),
        .cpuA(cpuA), .cpuD(cpuD), .cpuQ(cpuQ), .cpuQv(cpuQv),
        .ldReq(ldReq), .ldA(ldA), .ldD(ldD), .ldAck(ldAck),
        .busy(busy), .ovr(ovr),
        .sdrRf(sdrRf), .sdrRd(sdrRd), .sdrWr(sdrWr),
        .sdrA(sdrA), .sdrD(sdrD), .sdrQ(sdrQ)
    );

    typedef struct {
        logic        rf, rd, wr;
        logic [18:0] a;
        logic [7:0]  d;
        logic [2:0]  exp_strb;   // {sdrRf, sdrRd, sdrWr}
        logic [23:0] exp_a;
        logic [15:0] exp_d;
    } vec_t;
    vec_t vecs[5];

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    bit m_on    = 1'b0;

    // Reference model: port is free TCMD clocks after each strobe; one pending slot.
    int          m_last, m_rd_at;
    logic        m_pv, m_ovr;
    int          m_pk;               // 1 refresh, 2 read, 3 write
    logic [18:0] m_pa;
    logic [7:0]  m_pd, m_q;
    logic [23:0] m_a, m_rd_addr;
    logic [15:0] m_d;
    logic        e_rf, e_rd, e_wr, e_ack;

    // SDRAM emulator state, driven from what the DUT actually strobes.
    int          s_rd_at;
    logic [23:0] s_rd_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got %0h want %0h", name, cyc, act, exp);
    endtask

    function automatic logic [15:0] rdval(input logic [23:0] a);
        if (a == 24'h02ABCD) return 16'h005A;
        return {a[7:0], a[15:8] ^ a[23:16] ^ 8'h96};
    endfunction

    task automatic model_reset();
        m_last = -100; m_rd_at = -100; m_pv = 1'b0; m_ovr = 1'b0; m_pk = 1;
        m_pa = '0; m_pd = '0; m_q = 8'hFF; m_a = '0; m_d = '0; m_rd_addr = '0;
        e_rf = 1'b1; e_rd = 1'b1; e_wr = 1'b1; e_ack = 1'b0;
    endtask

    // Advance the model over the coming edge using this cycle's inputs.
    task automatic model_edge();
        bit          idle, req, issue_cpu, from_pend, issue_ld;
        int          nk, kind;
        logic [18:0] a;
        logic [7:0]  d;
        logic [15:0] rv;
        nk        = cpuWr ? 3 : (cpuRd ? 2 : 1);
        idle      = (cyc >= m_last + TCMD - 1);
        req       = cpuCe && (cpuRf || cpuRd || cpuWr);
        issue_cpu = idle && ready && (m_pv || req);
        from_pend = issue_cpu && m_pv;
        issue_ld  = idle && ready && !m_pv && !req && ldReq;
        e_rf = 1'b1; e_rd = 1'b1; e_wr = 1'b1; e_ack = 1'b0;
        if (cyc + 1 == m_rd_at + TRD) begin
            rv  = rdval(m_rd_addr);
            m_q = rv[7:0];
        end
        if (issue_cpu) begin
            kind   = from_pend ? m_pk : nk;
            a      = from_pend ? m_pa : cpuA;
            d      = from_pend ? m_pd : cpuD;
            m_last = cyc + 1;
            m_a    = {5'd0, a};
            m_d    = {d, d};
            if (kind == 3) e_wr = 1'b0;
            else if (kind == 1) e_rf = 1'b0;
            else begin
                e_rd      = 1'b0;
                m_rd_at   = cyc + 1;
                m_rd_addr = {5'd0, a};
            end
        end else if (issue_ld) begin
            m_last = cyc + 1;
            m_a    = 24'(ldA);
            m_d    = {ldD, ldD};
            e_wr   = 1'b0;
            e_ack  = 1'b1;
        end
        if (req && m_pv && !from_pend) m_ovr = 1'b1;
        if (from_pend) m_pv = 1'b0;
        if (req && !(issue_cpu && !from_pend)) begin
            m_pv = 1'b1; m_pk = nk; m_pa = cpuA; m_pd = cpuD;
        end
    endtask

    task automatic step();
        if (m_on) model_edge();
        @(posedge clock);
        #1;
        cyc++;
        if (m_on) begin
            check("ctl{rf,rd,wr,ack,busy,ovr,qv}",
                  {sdrRf, sdrRd, sdrWr, ldAck, busy, ovr, cpuQv},
                  {e_rf, e_rd, e_wr, e_ack, (cyc >= m_last && cyc <= m_last + TCMD - 2),
                   m_ovr, (cyc == m_rd_at + TRD)});
            check("sdrA", sdrA, m_a);
            check("sdrD", sdrD, m_d);
            check("cpuQ", cpuQ, m_q);
        end
        if (sdrRd === 1'b0) begin
            s_rd_at   = cyc;
            s_rd_addr = sdrA;
        end
        if (cyc == s_rd_at + TRD - 1 || cyc == s_rd_at + TRD) sdrQ = rdval(s_rd_addr);
        else sdrQ = 16'($urandom);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy !== 1'b0 && t < 4 * TCMD) begin
            step();
            t++;
        end
        check("wait_idle", busy, 1'b0);
    endtask

    task automatic clear_cpu();
        cpuCe = 1'b0; cpuRf = 1'b0; cpuRd = 1'b0; cpuWr = 1'b0;
    endtask

    initial begin
        int          n, s, prev, t;
        logic [2:0]  acc;
        logic        qv_seen;
        logic [23:0] ld_addrs[4];
        logic [7:0]  ld_data[4];

        vecs[0] = '{1'b1, 1'b1, 1'b1, 19'h00001, 8'hC3, 3'b110, 24'h000001, 16'hC3C3};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 19'h7FFFF, 8'h00, 3'b101, 24'h07FFFF, 16'h0000};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 19'h12345, 8'hA5, 3'b011, 24'h012345, 16'hA5A5};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 19'h00000, 8'hFF, 3'b110, 24'h000000, 16'hFFFF};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 19'h40000, 8'h5A, 3'b101, 24'h040000, 16'h5A5A};

        reset = 1'b1; ready = 1'b1; clear_cpu();
        cpuA = '0; cpuD = '0; ldReq = 1'b0; ldA = '0; ldD = '0; sdrQ = '0;
        s_rd_at = -100; s_rd_addr = '0;
        model_reset();
        repeat (3) step();
        check("rst_strobes", {sdrRf, sdrRd, sdrWr}, 3'b111);
        check("rst_sdrA", sdrA, 24'h0);
        check("rst_sdrD", sdrD, 16'h0);
        check("rst_cpuQ", cpuQ, 8'hFF);
        check("rst_flags{busy,ovr,qv,ack}", {busy, ovr, cpuQv, ldAck}, 4'b0000);
        reset = 1'b0;
        model_reset();
        m_on = 1'b1;
        repeat (3) step();

        // Single-command priority vectors.
        foreach (vecs[i]) begin
            wait_idle();
            cpuCe = 1'b1; cpuRf = vecs[i].rf; cpuRd = vecs[i].rd; cpuWr = vecs[i].wr;
            cpuA = vecs[i].a; cpuD = vecs[i].d;
            step();
            clear_cpu();
            check($sformatf("vec%0d_strobe", i), {sdrRf, sdrRd, sdrWr}, vecs[i].exp_strb);
            check($sformatf("vec%0d_sdrA", i), sdrA, vecs[i].exp_a);
            check($sformatf("vec%0d_sdrD", i), sdrD, vecs[i].exp_d);
            step();
            check($sformatf("vec%0d_release", i), {sdrRf, sdrRd, sdrWr}, 3'b111);
        end

        // CPU read with its data returning TRD clocks after the strobe.
        wait_idle();
        n = cyc;
        cpuCe = 1'b1; cpuRd = 1'b1; cpuA = 19'h2ABCD; cpuD = 8'h00;
        step();
        clear_cpu();
        check("rd_strobe_n+1", sdrRd, 1'b0);
        check("rd_sdrA", sdrA, 24'h02ABCD);
        step();
        check("rd_strobe_one_clock", sdrRd, 1'b1);
        while (cyc < n + 1 + TRD) step();
        check("rd_cpuQv_n+7", cpuQv, 1'b1);
        check("rd_cpuQ", cpuQ, 8'h5A);

        // All three request bits plus a loader request in the same clock.
        wait_idle();
        n = cyc;
        cpuCe = 1'b1; cpuRf = 1'b1; cpuRd = 1'b1; cpuWr = 1'b1;
        cpuA = 19'h00100; cpuD = 8'hC3;
        ldReq = 1'b1; ldA = 24'h123456; ldD = 8'h3C;
        step();
        clear_cpu();
        check("prio_strobe", {sdrRf, sdrRd, sdrWr, ldAck}, 4'b1100);
        check("prio_sdrD", sdrD, 16'hC3C3);
        repeat (TCMD - 1) step();
        check("prio_no_early_ack", ldAck, 1'b0);
        step();
        check("prio_ld_ack_tcmd_later", {ldAck, sdrRf, sdrRd, sdrWr}, 4'b1110);
        check("prio_ld_sdrA", sdrA, 24'h123456);
        check("prio_ld_sdrD", sdrD, 16'h3C3C);
        ldReq = 1'b0;

        // Loader stream of four sequential bytes.
        wait_idle();
        for (int k = 0; k < 4; k++) begin
            ld_addrs[k] = 24'hA00000 + 24'(k);
            ld_data[k]  = 8'h11 * 8'(k + 1);
        end
        ldReq = 1'b1; ldA = ld_addrs[0]; ldD = ld_data[0];
        prev = -1;
        for (int k = 0; k < 4; k++) begin
            t = 0;
            do begin
                step();
                t++;
            end while (ldAck !== 1'b1 && t < 3 * TCMD);
            check($sformatf("stream%0d_ack", k), ldAck, 1'b1);
            check($sformatf("stream%0d_sdrA", k), sdrA, ld_addrs[k]);
            check($sformatf("stream%0d_sdrD", k), sdrD, {ld_data[k], ld_data[k]});
            if (k > 0) check($sformatf("stream%0d_spacing", k), 32'(cyc - prev), 32'(TCMD));
            prev = cyc;
            if (k < 3) begin
                ldA = ld_addrs[k + 1];
                ldD = ld_data[k + 1];
            end else ldReq = 1'b0;
        end

        // CPU request behind an in-flight loader op, then an overrun in WAIT.
        wait_idle();
        ldReq = 1'b1; ldA = 24'h000777; ldD = 8'h42;
        step();
        s = cyc;
        check("cont_ld_ack", ldAck, 1'b1);
        ldReq = 1'b0;
        step();
        step();
        cpuCe = 1'b1; cpuRf = 1'b1; cpuA = 19'h00055;
        step();
        clear_cpu();
        while (cyc < s + TCMD) step();
        check("cont_rf_at_s+8", {sdrRf, sdrRd, sdrWr}, 3'b011);
        step();
        cpuCe = 1'b1; cpuRd = 1'b1; cpuA = 19'h01111;
        step();
        clear_cpu();
        step();
        cpuCe = 1'b1; cpuWr = 1'b1; cpuA = 19'h02222; cpuD = 8'h77;
        step();
        clear_cpu();
        check("ovr_set", ovr, 1'b1);
        while (cyc < s + 2 * TCMD) step();
        check("ovr_second_wins", {sdrRf, sdrRd, sdrWr}, 3'b110);
        check("ovr_second_sdrA", sdrA, 24'h002222);
        check("ovr_second_sdrD", sdrD, 16'h7777);

        // Reset in the middle of a read's WAIT.
        wait_idle();
        cpuCe = 1'b1; cpuRd = 1'b1; cpuA = 19'h00042;
        step();
        clear_cpu();
        repeat (3) step();
        reset = 1'b1;
        m_on  = 1'b0;
        #1;
        check("midrst_strobes", {sdrRf, sdrRd, sdrWr}, 3'b111);
        check("midrst_sdrA", sdrA, 24'h0);
        check("midrst_cpuQ", cpuQ, 8'hFF);
        check("midrst_busy_ovr", {busy, ovr}, 2'b00);
        step();
        step();
        reset = 1'b0;
        model_reset();
        m_on = 1'b1;
        qv_seen = 1'b0;
        acc = 3'b111;
        repeat (TRD + 4) begin
            step();
            qv_seen = qv_seen | cpuQv;
            acc = acc & {sdrRf, sdrRd, sdrWr};
        end
        check("midrst_no_late_data", qv_seen, 1'b0);
        check("midrst_no_strobe", acc, 3'b111);

        // ready low holds both a CPU read and a loader write.
        wait_idle();
        ready = 1'b0;
        cpuCe = 1'b1; cpuRd = 1'b1; cpuA = 19'h0ABCD;
        ldReq = 1'b1; ldA = 24'h0000AA; ldD = 8'hEE;
        step();
        clear_cpu();
        acc = {sdrRf, sdrRd, sdrWr};
        repeat (6) begin
            step();
            acc = acc & {sdrRf, sdrRd, sdrWr};
        end
        check("rdy0_no_strobe", acc, 3'b111);
        ready = 1'b1;
        step();
        check("rdy1_cpu_first", {sdrRf, sdrRd, sdrWr, ldAck}, 4'b1010);
        check("rdy1_cpu_sdrA", sdrA, 24'h00ABCD);
        repeat (TCMD - 1) step();
        check("rdy1_ld_not_early", ldAck, 1'b0);
        step();
        check("rdy1_ld_after", {ldAck, sdrWr}, 2'b10);
        check("rdy1_ld_sdrA", sdrA, 24'h0000AA);
        ldReq = 1'b0;

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cpuCe = ($urandom_range(5) == 0);
            {cpuRf, cpuRd, cpuWr} = 3'($urandom);
            cpuA = 19'($urandom);
            cpuD = 8'($urandom);
            if (ldAck === 1'b1 || !ldReq) begin
                ldReq = ($urandom_range(3) == 0);
                ldA   = LAW'($urandom);
                ldD   = 8'($urandom);
            end else if ($urandom_range(40) == 0) begin
                ldReq = 1'b0;
            end
            if (ready) ready = ($urandom_range(40) != 0);
            else ready = ($urandom_range(3) == 0);
            step();
        end
        clear_cpu();
        ldReq = 1'b0;
        ready = 1'b1;
        repeat (3 * TCMD) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
